// File: rtl/wb_commit_unit.sv
// Writeback commit: GPR file and HI/LO architectural state, updated from the MEM/WB bundle,
// with write-through bypassed decode read ports and a commit counter.
module wb_commit_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteW,
    input  logic             MemtoRegW,
    input  logic             hilowriteW,
    input  logic [31:0]      aluoutW,
    input  logic [31:0]      readdataW,
    input  logic [63:0]      hiloresW,
    input  logic [4:0]       writeregW,
    input  logic [4:0]       ra1D,
    input  logic [4:0]       ra2D,
    output logic [31:0]      rd1D,
    output logic [31:0]      rd2D,
    output logic [63:0]      hiloD,
    output logic [31:0]      resultW,
    output logic [CNT_W-1:0] commit_cnt
);

    logic [31:0]      gpr_q [32];
    logic [31:0]      gpr_d [32];
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gpr_we;
    logic             hilo_we;

    // Enables are masked while reset is held so a presented write is neither bypassed nor kept.
    assign gpr_we  = RegWriteW && reset && (writeregW != 5'd0);
    assign hilo_we = hilowriteW && reset;

    always_comb begin
        resultW = MemtoRegW ? readdataW : aluoutW;
        gpr_d   = gpr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        if (gpr_we) begin
            gpr_d[writeregW] = resultW;
        end
        if (hilo_we) begin
            hi_d = hiloresW[63:32];
            lo_d = hiloresW[31:0];
        end
        if (gpr_we || hilo_we) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        rd1D = '0;
        rd2D = '0;
        if (ra1D != 5'd0) begin
            rd1D = (gpr_we && (writeregW == ra1D)) ? resultW : gpr_q[ra1D];
        end
        if (ra2D != 5'd0) begin
            rd2D = (gpr_we && (writeregW == ra2D)) ? resultW : gpr_q[ra2D];
        end
        hiloD = hilo_we ? hiloresW : {hi_q, lo_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else begin
            gpr_q <= gpr_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
        end
    end

    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: reference model of GPR/HI/LO/counter, post-edge
// expectations queued at drive time and compared after the commit edge.
module tb_wb_commit_unit;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWriteW, MemtoRegW, hilowriteW;
    logic [31:0]   aluoutW, readdataW;
    logic [63:0]   hiloresW;
    logic [4:0]    writeregW, ra1D, ra2D;
    logic [31:0]   rd1D, rd2D, resultW;
    logic [63:0]   hiloD;
    logic [CW-1:0] commit_cnt;

    wb_commit_unit #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .hilowriteW (hilowriteW),
        .aluoutW    (aluoutW),
        .readdataW  (readdataW),
        .hiloresW   (hiloresW),
        .writeregW  (writeregW),
        .ra1D       (ra1D),
        .ra2D       (ra2D),
        .rd1D       (rd1D),
        .rd2D       (rd2D),
        .hiloD      (hiloD),
        .resultW    (resultW),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0]   m_gpr [32];
    logic [31:0]   m_hi, m_lo;
    logic [CW-1:0] m_cnt;

    typedef struct {
        string       tag;
        int          kind;
        logic [63:0] exp;
    } sb_t;
    sb_t sbq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_hi  = '0;
        m_lo  = '0;
        m_cnt = '0;
    endtask

    task automatic drain(input string tag);
        sb_t e;
        logic [63:0] obs;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
                0:       obs = {32'd0, rd1D};
                1:       obs = {32'd0, rd2D};
                2:       obs = hiloD;
                default: obs = {{(64-CW){1'b0}}, commit_cnt};
            endcase
            chk({tag, "/", e.tag}, obs, e.exp);
        end
    endtask

    // One MEM/WB bundle: check combinational outputs, queue post-edge state, commit, compare.
    task automatic step(input string tag, input logic rw, input logic mtr, input logic hw,
                        input logic [31:0] alu, input logic [31:0] ld, input logic [63:0] hr,
                        input logic [4:0] wr, input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] res, e1, e2;
        sb_t e;
        @(negedge clk);
        RegWriteW = rw; MemtoRegW = mtr; hilowriteW = hw;
        aluoutW = alu; readdataW = ld; hiloresW = hr;
        writeregW = wr; ra1D = a1; ra2D = a2;
        #1;
        res = mtr ? ld : alu;
        e1 = (a1 == 0) ? 32'd0 : ((rw && wr == a1) ? res : m_gpr[a1]);
        e2 = (a2 == 0) ? 32'd0 : ((rw && wr == a2) ? res : m_gpr[a2]);
        chk({tag, "/resultW"}, {32'd0, resultW}, {32'd0, res});
        chk({tag, "/rd1D_pre"}, {32'd0, rd1D}, {32'd0, e1});
        chk({tag, "/rd2D_pre"}, {32'd0, rd2D}, {32'd0, e2});
        chk({tag, "/hiloD_pre"}, hiloD, hw ? hr : {m_hi, m_lo});
        if (rw && wr != 0) m_gpr[wr] = res;
        if (hw) {m_hi, m_lo} = hr;
        if ((rw && wr != 0) || hw) m_cnt = m_cnt + 1'b1;
        e.tag = "rd1D_post";  e.kind = 0; e.exp = {32'd0, (a1 == 0) ? 32'd0 : m_gpr[a1]}; sbq.push_back(e);
        e.tag = "rd2D_post";  e.kind = 1; e.exp = {32'd0, (a2 == 0) ? 32'd0 : m_gpr[a2]}; sbq.push_back(e);
        e.tag = "hiloD_post"; e.kind = 2; e.exp = {m_hi, m_lo};                           sbq.push_back(e);
        e.tag = "cnt_post";   e.kind = 3; e.exp = {{(64-CW){1'b0}}, m_cnt};               sbq.push_back(e);
        @(posedge clk);
        #1;
        RegWriteW = 1'b0; hilowriteW = 1'b0;
        #1;
        drain(tag);
    endtask

    task automatic bubble(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 5'd0, 5'd1, 5'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        RegWriteW = 1'b0; MemtoRegW = 1'b0; hilowriteW = 1'b0;
        aluoutW = '0; readdataW = '0; hiloresW = '0;
        writeregW = '0; ra1D = 5'd5; ra2D = 5'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset/rd1D", {32'd0, rd1D}, 64'd0);
        chk("reset/hiloD", hiloD, 64'd0);
        chk("reset/cnt", {60'd0, commit_cnt}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        step("w5", 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 64'h0, 5'd5, 5'd5, 5'd0);

        // Asynchronous reset pulse while a write is presented.
        @(negedge clk);
        RegWriteW = 1'b1; MemtoRegW = 1'b0; writeregW = 5'd5; aluoutW = 32'h1234; ra1D = 5'd5;
        #2;
        reset = 1'b0;
        #1;
        chk("rstpulse/rd1D_now", {32'd0, rd1D}, 64'd0);
        chk("rstpulse/cnt_now", {60'd0, commit_cnt}, 64'd0);
        @(posedge clk);
        #1;
        chk("rstpulse/rd1D_edge", {32'd0, rd1D}, 64'd0);
        chk("rstpulse/cnt_edge", {60'd0, commit_cnt}, 64'd0);
        @(negedge clk);
        RegWriteW = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rstpulse/rd1D_rel", {32'd0, rd1D}, 64'd0);

        step("alu8",  1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h11111111, 64'h0, 5'd8, 5'd8, 5'd8);
        step("load8", 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h11111111, 64'h0, 5'd8, 5'd8, 5'd8);
        chk("sel/cnt2", {60'd0, commit_cnt}, 64'd2);

        step("zero", 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 64'h0, 5'd0, 5'd0, 5'd0);

        step("w3a",     1'b1, 1'b0, 1'b0, 32'hA, 32'h0, 64'h0, 5'd3, 5'd3, 5'd3);
        step("nobyp3",  1'b0, 1'b0, 1'b0, 32'hB, 32'h0, 64'h0, 5'd3, 5'd3, 5'd3);
        step("byp3",    1'b1, 1'b0, 1'b0, 32'hB, 32'h0, 64'h0, 5'd3, 5'd3, 5'd3);

        step("hilo_gpr9", 1'b1, 1'b0, 1'b1, 32'h7, 32'h0, 64'h00000001_FFFFFFFE, 5'd9, 5'd9, 5'd3);
        step("hilo_only", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 64'h89ABCDEF_01234567, 5'd9, 5'd9, 5'd8);

        // Unknown data with enables low must leave state intact.
        step("xdata", 1'b0, 1'b0, 1'b0, 32'hx, 32'hx, 64'hx, 5'd9, 5'd9, 5'd3);

        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step("wrap", 1'b1, 1'b0, 1'b0, 32'h100 + i, 32'h0, 64'h0, 5'(i % 31 + 1), 5'(i % 31 + 1), 5'd1);
        end
        chk("wrap/cnt17", {60'd0, commit_cnt}, 64'd1);
        for (int i = 0; i < 16; i++) begin
            bubble("bub");
            step("inter", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 64'(i) << 8, 5'd0, 5'd2, 5'd4);
        end
        chk("bub/cnt", {60'd0, commit_cnt}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
